// File: rtl/ps2_transmitter.sv
// ps2_transmitter: host-to-device PS/2 command byte sender with open-drain line control.
// Inhibit, request-to-send, clocked shift by device edges, ACK sampling, timeout recovery.
module ps2_transmitter #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       ps2_clk_low,
    output logic       ps2_data_low,
    output logic       tx_done,
    output logic       tx_error
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQUEST, SHIFT, ACK, WAIT_IDLE, DONE} state_t;

    state_t        state;
    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_prev;
    logic [7:0]    data_q;
    logic [3:0]    edge_cnt;
    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          ack_err;
    logic          fall;
    logic          tmo_hit;

    assign fall     = clk_prev & ~clk_sync[1];
    assign tmo_hit  = tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
    assign tx_ready = state == IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            clk_sync     <= 2'b11;
            data_sync    <= 2'b11;
            clk_prev     <= 1'b1;
            data_q       <= '0;
            edge_cnt     <= '0;
            inh_cnt      <= '0;
            tmo_cnt      <= '0;
            ack_err      <= 1'b0;
            ps2_clk_low  <= 1'b0;
            ps2_data_low <= 1'b0;
            tx_done      <= 1'b0;
            tx_error     <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
            tx_done   <= 1'b0;
            tx_error  <= 1'b0;
            case (state)
                IDLE: if (tx_valid) begin
                    data_q      <= tx_data;
                    inh_cnt     <= '0;
                    ps2_clk_low <= 1'b1;
                    state       <= INHIBIT;
                end
                INHIBIT: begin
                    inh_cnt <= inh_cnt + 1'b1;
                    if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
                        ps2_data_low <= 1'b1;
                        state        <= REQUEST;
                    end
                end
                REQUEST: begin
                    ps2_clk_low <= 1'b0;
                    edge_cnt    <= '0;
                    tmo_cnt     <= '0;
                    state       <= SHIFT;
                end
                SHIFT, ACK, WAIT_IDLE: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (tmo_hit) begin
                        ps2_clk_low  <= 1'b0;
                        ps2_data_low <= 1'b0;
                        tx_done      <= 1'b1;
                        tx_error     <= 1'b1;
                        state        <= DONE;
                    end else if (state == SHIFT) begin
                        if (fall) begin
                            edge_cnt <= edge_cnt + 1'b1;
                            // edge_cnt holds the count before this edge: 0..7 data, 8 parity, 9 stop
                            if (edge_cnt == 4'd9) begin
                                ps2_data_low <= 1'b0;
                                state        <= ACK;
                            end else begin
                                ps2_data_low <= edge_cnt == 4'd8 ? ^data_q : ~data_q[edge_cnt[2:0]];
                            end
                        end
                    end else if (state == ACK) begin
                        if (fall) begin
                            ack_err <= data_sync[1];
                            state   <= WAIT_IDLE;
                        end
                    end else if (clk_sync[1] && data_sync[1]) begin
                        tx_done  <= 1'b1;
                        tx_error <= ack_err;
                        state    <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_transmitter.sv
// tb_ps2_transmitter: directed table of transfers against a clocked PS/2 device model.
module tb_ps2_transmitter;
    localparam int INH = 8;
    localparam int TMO = 2000;

    typedef struct {
        logic [7:0] data;
        bit         ack;
        bit         silent;
        bit         par;
        bit         err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_low, ps2_data_low, tx_done, tx_error;
    wire        ps2_clk_line  = dev_clk & ~ps2_clk_low;
    wire        ps2_data_line = dev_data & ~ps2_data_low;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    ps2_transmitter #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk_line), .ps2_data(ps2_data_line),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ps2_clk_low(ps2_clk_low), .ps2_data_low(ps2_data_low),
        .tx_done(tx_done), .tx_error(tx_error)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Device: waits for request, then for each bit samples mid-high and produces a 40-cycle clock
    task automatic device(input bit ack, input bit silent, input int nfalls,
                          output logic [10:0] frame, output bit seen);
        seen  = 1'b0;
        frame = '0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = ps2_data_low && !ps2_clk_low;
        end
        if (!seen || silent) return;
        for (int k = 0; k < nfalls; k++) begin
            repeat (10) @(negedge clk);
            frame[k] = ps2_data_line;
            if (k == 10 && ack) dev_data = 1'b0;
            repeat (10) @(negedge clk);
            dev_clk = 1'b0;
            repeat (20) @(negedge clk);
            dev_clk = 1'b1;
        end
        if (nfalls == 11) begin
            repeat (10) @(negedge clk);
            dev_data = 1'b1;
        end
    endtask

    task automatic host(input int bound, output bit got, output bit err, output int lat,
                        output int low_cnt, output bit ready_seen, output bit spur,
                        output bit lines, output bit ready_after);
        got = 0; err = 0; lat = 0; low_cnt = 0; ready_seen = 0; spur = 0; lines = 1; ready_after = 0;
        for (int i = 1; i <= bound && !got; i++) begin
            if (ps2_clk_low) low_cnt++;
            if (tx_ready) ready_seen = 1;
            if (tx_error && !tx_done) spur = 1;
            if (tx_done) begin
                got   = 1;
                err   = tx_error;
                lat   = i;
                lines = ps2_clk_low | ps2_data_low;
            end else begin
                @(negedge clk);
            end
        end
        if (got) begin
            @(negedge clk);
            ready_after = tx_ready;
        end
    endtask

    task automatic xfer(input vec_t v, input string tag);
        logic [10:0] fr;
        bit seen, got, err, rs, sp, ln, ra;
        int lat, lc;
        @(negedge clk);
        chk({tag, "_ready_before"}, tx_ready, 1);
        tx_data  = v.data;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        fork
            device(v.ack, v.silent, 11, fr, seen);
            host(3000, got, err, lat, lc, rs, sp, ln, ra);
            begin
                repeat (50) @(negedge clk);
                tx_data  = ~v.data;
                tx_valid = 1'b1;
                repeat (100) @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        chk({tag, "_request_seen"}, seen, 1);
        chk({tag, "_done"}, got, 1);
        chk({tag, "_error"}, err, v.err);
        chk({tag, "_clk_low_cycles"}, lc, INH + 1);
        chk({tag, "_ready_low_during"}, rs, 0);
        chk({tag, "_err_without_done"}, sp, 0);
        chk({tag, "_lines_at_done"}, ln, 0);
        chk({tag, "_ready_after"}, ra, 1);
        if (v.silent) chk({tag, "_timeout_latency"}, lat, INH + 1 + TMO + 1);
        else chk({tag, "_frame"}, fr, {1'b1, v.par, v.data, 1'b0});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        vec_t ff_vec;
        logic [10:0] fr;
        bit seen, d;
        vecs[0] = '{8'hED, 1, 0, 1, 0};
        vecs[1] = '{8'h01, 1, 0, 0, 0};
        vecs[2] = '{8'h00, 1, 0, 1, 0};
        vecs[3] = '{8'hA5, 0, 0, 1, 1};
        vecs[4] = '{8'h3C, 0, 1, 1, 1};
        vecs[5] = '{8'h80, 1, 0, 0, 0};
        ff_vec  = '{8'hFF, 1, 0, 1, 0};

        repeat (2) @(negedge clk);
        chk("rst_ready", tx_ready, 1);
        chk("rst_clk_low", ps2_clk_low, 0);
        chk("rst_data_low", ps2_data_low, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_error", tx_error, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_ready", tx_ready, 1);

        for (int i = 0; i < 6; i++) xfer(vecs[i], $sformatf("vec%0d", i));

        @(negedge clk);
        tx_data  = 8'h50;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        device(1, 0, 4, fr, seen);
        chk("rst_mid_request_seen", seen, 1);
        repeat (5) @(negedge clk);
        chk("rst_mid_ready_pre", tx_ready, 0);
        chk("rst_mid_data_low_pre", ps2_data_low, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_clk_low", ps2_clk_low, 0);
        chk("rst_mid_data_low", ps2_data_low, 0);
        chk("rst_mid_ready", tx_ready, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        d = 0;
        repeat (30) begin
            @(negedge clk);
            if (tx_done) d = 1;
        end
        chk("rst_mid_no_done", d, 0);
        xfer(ff_vec, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_transmitter.md
PS2_TRANSMITTER -- requirements
Module: ps2_transmitter

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000, number of clk cycles PS/2 clock is held low before the request (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 750000, maximum clk cycles from clock release to the end of the frame (15 ms at 50 MHz).
REQ-003 clk  input  1  system clock; single clock domain; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 ps2_clk  input  1  PS/2 clock line as sensed (asynchronous).
REQ-006 ps2_data  input  1  PS/2 data line as sensed (asynchronous).
REQ-007 tx_data  input  8  command byte to send to the keyboard.
REQ-008 tx_valid  input  1  request; byte accepted when tx_valid and tx_ready are both high.
REQ-009 tx_ready  output  1  high only in IDLE.
REQ-010 ps2_clk_low  output  1  1 = pull PS/2 clock low (open-drain); 0 = release.
REQ-011 ps2_data_low  output  1  1 = pull PS/2 data low (open-drain); 0 = release.
REQ-012 tx_done  output  1  one-cycle pulse at the end of every accepted transfer.
REQ-013 tx_error  output  1  valid with tx_done; 1 = no ACK or timeout.

Function
REQ-014 ps2_clk and ps2_data SHALL pass through 2-flop synchronizers; a falling edge is previous-synced=1 and synced=0, detected 3 cycles after the pin transition at most.
REQ-015 Accepted byte SHALL be latched; frame = start 0, tx_data[0]..tx_data[7] LSB first, odd parity (~^tx_data), stop 1.
REQ-016 States SHALL be IDLE, INHIBIT, REQUEST, SHIFT, ACK, WAIT_IDLE, DONE.
REQ-017 IDLE: both drive outputs 0, tx_ready=1; on accept go to INHIBIT the next cycle.
REQ-018 INHIBIT: ps2_clk_low=1 for exactly INHIBIT_CYCLES cycles, ps2_data_low=0; then REQUEST.
REQ-019 REQUEST: one cycle with ps2_clk_low=1 and ps2_data_low=1 (start bit); then SHIFT with ps2_clk_low=0, ps2_data_low=1, edge counter=0, timeout counter cleared.
REQ-020 SHIFT: on each detected falling edge the counter SHALL increment; the cycle after edge n (n=1..8) drive bit tx_data[n-1]; after edge 9 drive parity; after edge 10 release data (stop); ps2_data_low = ~bit.
REQ-021 ACK: on falling edge 11, sample synced ps2_data; 0 = ACK ok, 1 = ack error; go to WAIT_IDLE.
REQ-022 WAIT_IDLE: wait until synced ps2_clk=1 and ps2_data=1, then DONE.
REQ-023 DONE: tx_done=1 for one cycle, tx_error=ack error; next cycle IDLE.
REQ-024 Timeout counter SHALL run from REQUEST exit until DONE; on reaching TIMEOUT_CYCLES in SHIFT, ACK or WAIT_IDLE: release both lines immediately, go to DONE with tx_error=1.
REQ-025 tx_valid outside IDLE SHALL be ignored; tx_data changes after accept SHALL not affect the frame.
REQ-026 Falling edges seen in IDLE, INHIBIT or REQUEST SHALL be ignored (device-to-host traffic is not this block's concern).
REQ-027 tx_error SHALL be 0 whenever tx_done is 0.

Reset
REQ-028 rst_n=0 SHALL asynchronously force IDLE, ps2_clk_low=0, ps2_data_low=0, tx_done=0, tx_error=0, counters=0, synchronizers=1; tx_ready=1 after reset.
REQ-029 Reset mid-frame SHALL release both lines in the same instant, with no tx_done pulse.

Verification (INHIBIT_CYCLES=8, TIMEOUT_CYCLES=2000, device model clocks at 40-cycle period)
REQ-030 Send 0xED, device ACKs -> device samples 0,1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done with tx_error=0; ps2_clk_low high exactly 8+1 cycles.
REQ-031 Send 0x01 then 0x00 back-to-back -> parity 0 then 1; tx_ready low from accept to one cycle after DONE.
REQ-032 Device never ACKs (data stays high on edge 11) -> tx_done with tx_error=1, lines released.
REQ-033 Device never clocks after REQUEST -> after 2000 cycles both drive outputs 0, tx_done with tx_error=1, then IDLE.
REQ-034 rst_n pulsed low during SHIFT after edge 4 -> outputs 0 immediately, no tx_done; new 0xFF send afterwards completes with parity 1.
REQ-035 tx_valid toggled and tx_data changed during a transfer -> no second accept; the transmitted byte is unchanged.
